rng_sched: RTL and testbench

Sequencer and arbiter for the LHCA random-number core. It seeds the automaton, holds off output through a warm-up period, and enforces a minimum diffusion stride between extracted words. It shares the single random stream among `NUM_REQ` requesters using round-robin arbitration. It sits between the `lhca` instance and consumers such as key generation and nonce logic.

---
 rtl/rng_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rng_sched.sv | 116 +++++++++++
 tb/tb_rng_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - Shared state type, default seed and sizing helper for the LHCA sequencer
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } rng_state_e;

  localparam logic [31:0] RNG_DEFAULT_SEED = 32'hA5A5_5A5A;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - Round-robin pick starting just after the last granted requester
module rr_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (en && !found && req[IW'(cand)]) begin
        found            = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        idx              = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rng_sched.sv
// rtl/rng_sched.sv - Seeds the LHCA, waits out warm-up, then shares its words among requesters
module rng_sched
  import rng_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               NUM_REQ       = 2,
  parameter int               WARMUP_CYCLES = 64,
  parameter int               STRIDE        = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED  = WIDTH'(RNG_DEFAULT_SEED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic               seed_load_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               rnd_valid_o,
  output logic [WIDTH-1:0]   rnd_o,
  output logic               ready_o,
  output logic               stuck_o,
  output logic               lhca_rst_o,
  output logic [WIDTH-1:0]   lhca_source_o,
  input  logic [WIDTH-1:0]   lhca_state_i
);

  localparam int IW = cnt_width(NUM_REQ);
  localparam int WW = cnt_width(WARMUP_CYCLES);
  localparam int SW = cnt_width(STRIDE);

  rng_state_e         state_q, state_d;
  logic [WIDTH-1:0]   seed_q;
  logic [IW-1:0]      last_q;
  logic [WW-1:0]      warm_q;
  logic [SW-1:0]      stride_q;
  logic               grant_en;
  logic               stuck_ev;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  // Precedence: disable beats reseed beats stuck recovery beats granting.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    stuck_ev = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else if (seed_load_i) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_LOAD;
        ST_LOAD:   state_d = ST_WARMUP;
        ST_WARMUP: if (warm_q == WW'(WARMUP_CYCLES - 1)) state_d = ST_RUN;
        ST_RUN: begin
          if (lhca_state_i == '0) begin
            stuck_ev = 1'b1;
            state_d  = ST_LOAD;
          end else begin
            grant_en = (stride_q == '0);
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req  (req_i),
    .last (last_q),
    .en   (grant_en),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign arb_valid = |arb_gnt;

  assign lhca_rst_o    = (state_q == ST_LOAD);
  assign lhca_source_o = (state_q != ST_LOAD) ? '0 :
                         (seed_q == '0)       ? DEFAULT_SEED : seed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= DEFAULT_SEED;
      last_q      <= IW'(NUM_REQ - 1);
      warm_q      <= '0;
      stride_q    <= '0;
      gnt_o       <= '0;
      rnd_valid_o <= 1'b0;
      rnd_o       <= '0;
      ready_o     <= 1'b0;
      stuck_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_o     <= (state_d == ST_RUN);
      stuck_o     <= stuck_o | stuck_ev;
      gnt_o       <= arb_gnt;
      rnd_valid_o <= arb_valid;
      if (seed_load_i) seed_q <= seed_i;
      warm_q <= (state_q == ST_WARMUP) ? warm_q + 1'b1 : '0;
      // Zero means eligible; a grant reloads so the next one lands STRIDE cycles later.
      if (arb_valid) begin
        stride_q <= SW'(STRIDE - 1);
        rnd_o    <= lhca_state_i;
        last_q   <= arb_idx;
      end else if (state_q != ST_RUN) begin
        stride_q <= '0;
      end else if (stride_q != '0) begin
        stride_q <= stride_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rng_sched.sv
// tb/tb_rng_sched.sv - Randomized bench for rng_sched against a cycle-count reference model
module tb_rng_sched;

  localparam int          WIDTH         = 32;
  localparam int          NUM_REQ       = 2;
  localparam int          WARMUP_CYCLES = 64;
  localparam int          STRIDE        = 4;
  localparam logic [31:0] DEF_SEED      = 32'hA5A5_5A5A;
  localparam logic [31:0] RULE150       = 32'h0000_0001;
  localparam int          M_IDLE = 0, M_LOAD = 1, M_WARM = 2, M_RUN = 3;

  logic               clk = 1'b0;
  logic               rst, en, seed_load, force_zero;
  logic [WIDTH-1:0]   seed;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid, ready, stuck, lhca_rst;
  logic [WIDTH-1:0]   rnd, lhca_source, lhca_state;
  logic [WIDTH-1:0]   lhca_q = 32'h1;

  int n_chk  = 0;
  int n_fail = 0;

  rng_sched #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .WARMUP_CYCLES(WARMUP_CYCLES), .STRIDE(STRIDE),
    .DEFAULT_SEED(DEF_SEED)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .seed_i(seed), .seed_load_i(seed_load),
    .req_i(req), .gnt_o(gnt), .rnd_valid_o(rnd_valid), .rnd_o(rnd), .ready_o(ready),
    .stuck_o(stuck), .lhca_rst_o(lhca_rst), .lhca_source_o(lhca_source),
    .lhca_state_i(lhca_state)
  );

  always #5 clk = ~clk;

  // Hybrid rule 90/150 automaton with null boundaries (cell 0 uses rule 150).
  function automatic logic [31:0] ca_step(input logic [31:0] s);
    return (s << 1) ^ (s >> 1) ^ (s & RULE150);
  endfunction

  function automatic logic [31:0] eff_seed(input logic [31:0] s);
    return (s == 32'h0) ? DEF_SEED : s;
  endfunction

  // Stand-in lhca instance.
  always @(posedge clk) lhca_q <= lhca_rst ? lhca_source : ca_step(lhca_q);
  assign lhca_state = force_zero ? '0 : lhca_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int                 m_mode, m_wleft, m_last, m_edge = 0, m_last_edge;
  logic [31:0]        m_seed, m_word, e_rnd;
  logic [NUM_REQ-1:0] e_gnt;
  logic               e_valid, e_stuck;
  logic               m_init = 1'b0;

  always @(posedge clk) begin : model
    int          nxt;
    int          c;
    logic        found;
    logic [31:0] sample;
    m_edge++;
    if (rst) begin
      m_mode  = M_IDLE;
      m_seed  = DEF_SEED;
      m_last  = NUM_REQ - 1;
      e_gnt   = '0;
      e_valid = 1'b0;
      e_rnd   = '0;
      e_stuck = 1'b0;
      m_init  = 1'b1;
    end else if (m_init) begin
      sample  = force_zero ? 32'h0 : m_word;
      m_word  = (m_mode == M_LOAD) ? eff_seed(m_seed) : ca_step(m_word);
      e_gnt   = '0;
      e_valid = 1'b0;
      nxt     = m_mode;
      found   = 1'b0;
      if (!en) nxt = M_IDLE;
      else if (seed_load) nxt = M_LOAD;
      else if (m_mode == M_IDLE) nxt = M_LOAD;
      else if (m_mode == M_LOAD) begin
        nxt     = M_WARM;
        m_wleft = WARMUP_CYCLES;
      end else if (m_mode == M_WARM) begin
        m_wleft--;
        if (m_wleft == 0) begin
          nxt         = M_RUN;
          m_last_edge = -1000000;
        end
      end else if (sample == 32'h0) begin
        e_stuck = 1'b1;
        nxt     = M_LOAD;
      end else if (m_edge - m_last_edge >= STRIDE) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          c = (m_last + i) % NUM_REQ;
          if (!found && (((req >> c) & 1) != 0)) begin
            found       = 1'b1;
            e_gnt       = NUM_REQ'(1 << c);
            e_valid     = 1'b1;
            e_rnd       = sample;
            m_last      = c;
            m_last_edge = m_edge;
          end
        end
      end
      if (seed_load) m_seed = seed;
      m_mode = nxt;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("gnt", gnt, e_gnt);
      check("rnd_valid", rnd_valid, e_valid);
      check("rnd", rnd, e_rnd);
      check("ready", ready, m_mode == M_RUN);
      check("stuck", stuck, e_stuck);
      check("lhca_rst", lhca_rst, m_mode == M_LOAD);
      check("lhca_source", lhca_source, (m_mode == M_LOAD) ? eff_seed(m_seed) : 32'h0);
    end
  end

  initial begin
    int lat, pulses, early, k;
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = '0; req = '0; force_zero = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Seed latched while disabled, then enable and time the warm-up.
    seed = 32'h1; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    req = 2'b11; en = 1'b1;
    lat = 0; pulses = 0; early = 0;
    while (ready !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lhca_rst === 1'b1) pulses++;
      if (gnt !== '0 && ready !== 1'b1) early++;
    end
    check("ready_lat", lat, WARMUP_CYCLES + 2);
    check("load_pulses", pulses, 1);
    check("early_gnt", early, 0);
    repeat (40) @(negedge clk);

    repeat (150) begin
      req = NUM_REQ'($urandom);
      @(negedge clk);
    end

    req = 2'b11; seed = 32'hDEADBEEF; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (80) @(negedge clk);

    seed = 32'h0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (75) @(negedge clk);
    force_zero = 1'b1;
    @(negedge clk);
    force_zero = 1'b0;
    repeat (80) @(negedge clk);
    check("stuck_sticky", stuck, 1'b1);

    // Disable mid-warm-up, then mid-run with requests pending.
    seed = 32'h1234_5678; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (80) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (80) @(negedge clk);

    // Reset exactly on a grant decision edge.
    k = 0;
    while (gnt === '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("gnt_seen", k < 50, 1'b1);
    repeat (STRIDE - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (gnt === '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("first_after_rst", gnt, 2'b01);

    repeat (600) begin
      rst        = ($urandom % 300) == 0;
      en         = ($urandom % 50) != 0;
      seed_load  = ($urandom % 80) == 0;
      seed       = (($urandom % 4) == 0) ? 32'h0 : $urandom;
      req        = NUM_REQ'($urandom);
      force_zero = ($urandom % 60) == 0;
      @(negedge clk);
    end
    rst = 1'b0; seed_load = 1'b0; force_zero = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
